// File: rtl/req_pend_pkg.sv
// ---------------------------------------------------------------------------
// req_pend_pkg : shared constants for the request-capture stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package req_pend_pkg;

  localparam int REQ_WIDTH = 16;
  localparam int REQ_IDX_W = $clog2(REQ_WIDTH);

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det : one-bit synchroniser with rising-edge or level event output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_det
  import req_pend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = MODE_EDGE
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != MODE_LEVEL) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= w_sync;
        end
      end

      // prev_q resets low, so a line held high through reset yields one edge
      assign evt_o = w_sync & ~prev_q;
    end else begin : g_level
      assign evt_o = w_sync;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/req_pending_latch.sv
// ---------------------------------------------------------------------------
// req_pending_latch : synchronises requests into sticky pending bits for the
//                     priority encoder, with per-index ack and overflow flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module req_pending_latch
  import req_pend_pkg::*;
#(
  parameter int WIDTH       = REQ_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = MODE_EDGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_in,
  input  logic [WIDTH-1:0]     mask,
  input  logic                 ack_valid,
  input  logic [REQ_IDX_W-1:0] ack_idx,
  input  logic                 clr_all,
  output logic [WIDTH-1:0]     pend_out,
  output logic                 pend_any,
  output logic [WIDTH-1:0]     overflow
);

  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_ack_hit;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] ovf_q,  ovf_d;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_line
      sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
      ) u_det (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_in[i]),
        .evt_o (w_event[i])
      );
    end
  endgenerate

  // Out-of-range indices simply match no line
  always_comb begin
    w_ack_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ack_hit[i] = ack_valid && (int'(ack_idx) == i);
    end
  end

  // Event beats ack on the same bit so no request is ever lost
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clr_all) begin
      pend_d = '0;
      ovf_d  = '0;
    end else begin
      pend_d = w_event | (pend_q & ~w_ack_hit);
      if (EDGE_MODE != MODE_LEVEL) begin
        ovf_d = ovf_q | (w_event & pend_q & ~w_ack_hit);
      end else begin
        ovf_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_out = pend_q & mask;
  assign pend_any = |pend_out;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_req_pending_latch.sv
// ---------------------------------------------------------------------------
// tb_req_pending_latch : directed bench for edge- and level-mode instances,
//                        checked every cycle against a request-history model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_req_pending_latch;

  localparam int W  = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  req_in = '0;
  logic [W-1:0]  mask = '1;
  logic          ack_valid = 1'b0;
  logic [3:0]    ack_idx = '0;
  logic          clr_all = 1'b0;

  logic [W-1:0]  pend_e, ovf_e, pend_l, ovf_l;
  logic          any_e, any_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  req_pending_latch #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(1)) u_edge (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .clr_all(clr_all),
    .pend_out(pend_e), .pend_any(any_e), .overflow(ovf_e)
  );

  req_pending_latch #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(0)) u_level (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .clr_all(clr_all),
    .pend_out(pend_l), .pend_any(any_l), .overflow(ovf_l)
  );

  // Model: the raw request as sampled on each of the last SS+1 edges
  logic [W-1:0] m_hist [SS+1];
  logic [W-1:0] m_pend_e = '0, m_ovf_e = '0, m_pend_l = '0;

  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] seen, seen_before, ev_e, ev_l, ackm;
    if (rst) begin
      for (int k = 0; k <= SS; k++) m_hist[k] <= '0;
      m_pend_e <= '0;
      m_ovf_e  <= '0;
      m_pend_l <= '0;
    end else begin
      seen        = m_hist[SS-1];
      seen_before = m_hist[SS];
      ev_l = seen;
      ev_e = seen & ~seen_before;
      ackm = ack_valid ? (W'(1) << ack_idx) : '0;
      if (clr_all) begin
        m_pend_e <= '0;
        m_ovf_e  <= '0;
        m_pend_l <= '0;
      end else begin
        m_pend_e <= ev_e | (m_pend_e & ~ackm);
        m_ovf_e  <= m_ovf_e | (ev_e & m_pend_e & ~ackm);
        m_pend_l <= ev_l | (m_pend_l & ~ackm);
      end
      for (int k = SS; k > 0; k--) m_hist[k] <= m_hist[k-1];
      m_hist[0] <= req_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 || rst === 1'b0) begin
      check("e_pend_out", 32'(pend_e), 32'(m_pend_e & mask));
      check("e_pend_any", 32'(any_e),  32'(|(m_pend_e & mask)));
      check("e_overflow", 32'(ovf_e),  32'(m_ovf_e));
      check("l_pend_out", 32'(pend_l), 32'(m_pend_l & mask));
      check("l_pend_any", 32'(any_l),  32'(|(m_pend_l & mask)));
      check("l_overflow", 32'(ovf_l),  32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] bits, input int hi, input int lo);
    req_in = req_in | bits;
    repeat (hi) tick();
    req_in = req_in & ~bits;
    repeat (lo) tick();
  endtask

  task automatic ack(input logic [3:0] idx);
    ack_valid = 1'b1;
    ack_idx   = idx;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic settle_and_clear();
    req_in = '0;
    repeat (SS + 2) tick();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    tick();
  endtask

  initial begin
    // Line held high through reset counts as one edge after release
    #1;
    rst    = 1'b1;
    req_in = 16'hFFFF;
    repeat (3) tick();
    check("rst_pend_held", 32'(pend_e), 32'h0);
    check("rst_ovf_held",  32'(ovf_e),  32'h0);
    rst = 1'b0;
    repeat (2) tick();
    check("rst_rel_c2", 32'(pend_e), 32'h0);
    tick();
    check("rst_rel_c3", 32'(pend_e), 32'hFFFF);
    settle_and_clear();

    // Single pulse on bit 5, then ack
    req_in[5] = 1'b1;
    repeat (2) tick();
    check("b5_c2", 32'(pend_e), 32'h0);
    tick();
    check("b5_c3", 32'(pend_e), 32'h0020);
    tick();
    req_in[5] = 1'b0;
    repeat (3) tick();
    check("b5_held", 32'(pend_e), 32'h0020);
    check("b5_any",  32'(any_e),  32'h1);
    ack(4'd5);
    check("b5_acked", 32'(pend_e), 32'h0);
    check("b5_any0",  32'(any_e),  32'h0);
    settle_and_clear();

    // Second edge on bit 9 while pending -> overflow, then clr_all
    pulse(16'h0200, 2, 2);
    pulse(16'h0200, 2, 3);
    check("b9_pend", 32'(pend_e), 32'h0200);
    check("b9_ovf",  32'(ovf_e),  32'h0200);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    check("b9_clr_pend", 32'(pend_e), 32'h0);
    check("b9_clr_ovf",  32'(ovf_e),  32'h0);
    settle_and_clear();

    // Event on bit 3 coincides with ack of bit 3
    pulse(16'h0008, 2, 3);
    check("b3_pend", 32'(pend_e), 32'h0008);
    req_in[3] = 1'b1;
    repeat (2) tick();
    ack(4'd3);
    req_in[3] = 1'b0;
    check("b3_setwins", 32'(pend_e), 32'h0008);
    check("b3_noovf",   32'(ovf_e),  32'h0);
    ack(4'd3);
    check("b3_cleared", 32'(pend_e), 32'h0);
    settle_and_clear();

    // Masked capture, unmask same cycle, ack of a non-pending bit
    mask = 16'h00FF;
    pulse(16'h1004, 2, 3);
    check("mask_lo", 32'(pend_e), 32'h0004);
    mask = 16'hFFFF;
    #1;
    check("mask_open", 32'(pend_e), 32'h1004);
    ack(4'd4);
    check("ack_nonpend", 32'(pend_e), 32'h1004);
    check("ack_nonpend_ovf", 32'(ovf_e), 32'h0);
    settle_and_clear();

    // Level mode: held request re-pends every cycle despite acks
    req_in[0] = 1'b1;
    repeat (3) tick();
    check("lvl_pend", 32'(pend_l), 32'h0001);
    ack_idx   = 4'd0;
    ack_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("lvl_repend", 32'(pend_l), 32'h0001);
      check("lvl_ovf",    32'(ovf_l),  32'h0);
    end
    ack_valid = 1'b0;
    check("edge_acked_once", 32'(pend_e), 32'h0);
    settle_and_clear();

    // Asynchronous reset mid-cycle clears state before the next edge
    pulse(16'h0200, 2, 2);
    pulse(16'h0200, 2, 3);
    check("pre_rst_ovf", 32'(ovf_e), 32'h0200);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pend", 32'(pend_e), 32'h0);
    check("async_rst_ovf",  32'(ovf_e),  32'h0);
    check("async_rst_any",  32'(any_e),  32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_idle", 32'(pend_e), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
